jamma_input_scanner: RTL and testbench

JAMMA_INPUT_SCANNER -- requirements
Module: jamma_input_scanner

---
 rtl/jamma_pkg.sv | 19 +
 rtl/jamma_input_scanner_if.sv | 28 ++
 rtl/jamma_debounce.sv | 55 +++++
 rtl/jamma_input_scanner.sv | 131 +++++++++++++
 tb/tb_jamma_input_scanner.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jamma_pkg.sv
// Shared definitions for the JAMMA input scanner: scan states, bank-A merge mask,
// idle (inactive, active-low) input value and counter widths.
package jamma_pkg;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } scanState_e;

    localparam logic [7:0] BANK_A_MASK = 8'hC0;
    localparam logic [7:0] INPUT_IDLE  = 8'hFF;

    localparam int SETTLE_W = 8;
    localparam int DEB_W    = 4;

    // One scan word: {coin[1:0], test, service, bank B[7:0], bank A[7:0]}
    localparam int RAW_W = 20;

endpackage

// File: rtl/jamma_input_scanner_if.sv
// Cabinet-side signal bundle of the JAMMA input scanner; the scanner uses the
// slave modport, the cabinet/harness side uses the master modport.
interface jamma_input_scanner_if;

    logic [7:0] JJOY;
    logic [5:0] JOYSTICK;
    logic [1:0] JCOIN;
    logic       JTEST;
    logic       JSERVICE;
    logic       JSELECT;
    logic [7:0] joystick1;
    logic [7:0] joystick2;
    logic [1:0] coin;
    logic       test_n;
    logic       service_n;
    logic       scan_valid;

    modport master (
        output JJOY, JOYSTICK, JCOIN, JTEST, JSERVICE,
        input  JSELECT, joystick1, joystick2, coin, test_n, service_n, scan_valid
    );

    modport slave (
        input  JJOY, JOYSTICK, JCOIN, JTEST, JSERVICE,
        output JSELECT, joystick1, joystick2, coin, test_n, service_n, scan_valid
    );

endinterface

// File: rtl/jamma_debounce.sv
// Per-bit scan debouncer: a bit's output flips only after DEB_SCANS consecutive
// evaluated scans disagree with it; any agreeing scan restarts the count.
module jamma_debounce
    import jamma_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEB_SCANS = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             evalEn_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] q_o
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_SCANS - 1);

    logic [WIDTH-1:0] deb_q, deb_d;
    logic [DEB_W-1:0] cnt_q [WIDTH];
    logic [DEB_W-1:0] cnt_d [WIDTH];

    // The flip happens on the scan that would bring the count to DEB_SCANS, so the
    // stored count never exceeds DEB_SCANS-1; the saturation guard is a backstop.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (evalEn_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (raw_i[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= DEB_LAST) begin
                    deb_d[i] = raw_i[i];
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_q <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o = deb_q;

endmodule

// File: rtl/jamma_input_scanner.sv
// JAMMA input scanner: alternates JSELECT between the two player banks, samples each
// after SETTLE_CYC cycles and publishes one snapshot per scan. Optional filter: JAMMA_DEBOUNCE_EN.
module jamma_input_scanner
    import jamma_pkg::*;
#(
    parameter int SETTLE_CYC = 8,
    parameter int DEB_SCANS  = 3
) (
    input  logic                  pclk,
    input  logic                  pll_lckd,
    jamma_input_scanner_if.slave  bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

    if (SETTLE_CYC < 2 || SETTLE_CYC > 255) begin : gSettleRangeChk
        $error("jamma_input_scanner: SETTLE_CYC must be 2..255");
    end
    if (DEB_SCANS < 1 || DEB_SCANS > 15) begin : gDebRangeChk
        $error("jamma_input_scanner: DEB_SCANS must be 1..15");
    end

    scanState_e           state_q, state_d;
    logic [SETTLE_W-1:0]  settleCnt_q, settleCnt_d;
    logic                 jselect_q, jselect_d;
    logic                 captureA, captureB;
    logic [7:0]           rawA_q, rawB_q;
    logic [3:0]           rawCab_q;
    logic                 scanDone_q;
    logic                 scanValid_q;
    logic [RAW_W-1:0]     rawScan;
    logic [RAW_W-1:0]     filtered;

    always_ff @(posedge pclk or negedge pll_lckd) begin
        if (!pll_lckd) begin
            state_q     <= SEL_A;
            settleCnt_q <= '0;
            jselect_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            settleCnt_q <= settleCnt_d;
            jselect_q   <= jselect_d;
        end
    end

    // JSELECT is registered from the next state, so it flips the cycle after a capture.
    always_comb begin
        state_d     = state_q;
        settleCnt_d = settleCnt_q + 1'b1;
        captureA    = 1'b0;
        captureB    = 1'b0;
        case (state_q)
            SEL_A: begin
                if (settleCnt_q == SETTLE_LAST) begin
                    captureA    = 1'b1;
                    settleCnt_d = '0;
                    state_d     = SEL_B;
                end
            end
            SEL_B: begin
                if (settleCnt_q == SETTLE_LAST) begin
                    captureB    = 1'b1;
                    settleCnt_d = '0;
                    state_d     = SEL_A;
                end
            end
            default: begin
                settleCnt_d = '0;
                state_d     = SEL_A;
            end
        endcase
        jselect_d = (state_d == SEL_B);
    end

    // The local DB9 stick only covers bank A bits 5:0; bits 7:6 pass JJOY through.
    always_ff @(posedge pclk or negedge pll_lckd) begin
        if (!pll_lckd) begin
            rawA_q      <= INPUT_IDLE;
            rawB_q      <= INPUT_IDLE;
            rawCab_q    <= '1;
            scanDone_q  <= 1'b0;
            scanValid_q <= 1'b0;
        end else begin
            if (captureA) begin
                rawA_q <= bus.JJOY & (BANK_A_MASK | {2'b00, bus.JOYSTICK});
            end
            if (captureB) begin
                rawB_q   <= bus.JJOY;
                rawCab_q <= {bus.JCOIN, bus.JTEST, bus.JSERVICE};
            end
            scanDone_q  <= captureB;
            scanValid_q <= scanDone_q;
        end
    end

    assign rawScan = {rawCab_q, rawB_q, rawA_q};

`ifdef JAMMA_DEBOUNCE_EN
    jamma_debounce #(
        .WIDTH     (RAW_W),
        .DEB_SCANS (DEB_SCANS)
    ) uDebounce (
        .clk_i    (pclk),
        .rst_ni   (pll_lckd),
        .evalEn_i (scanDone_q),
        .raw_i    (rawScan),
        .q_o      (filtered)
    );
`else
    logic [RAW_W-1:0] held_q;

    always_ff @(posedge pclk or negedge pll_lckd) begin
        if (!pll_lckd) begin
            held_q <= '1;
        end else if (scanDone_q) begin
            held_q <= rawScan;
        end
    end

    assign filtered = held_q;
`endif

    assign bus.JSELECT    = jselect_q;
    assign bus.scan_valid = scanValid_q;
    assign bus.joystick1  = filtered[7:0];
    assign bus.joystick2  = filtered[15:8];
    assign bus.test_n     = filtered[17];
    assign bus.service_n  = filtered[16];
    assign bus.coin       = filtered[19:18];

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Self-checking bench for jamma_input_scanner: a scan-level reference model checked every
// cycle, plus literal checks of reset, first-scan timing, debounce and mid-scan reset.
module tb_jamma_input_scanner;

    localparam int SETTLE = 8;
    localparam int DEB    = 3;
    localparam int PERIOD = 2 * SETTLE;
`ifdef JAMMA_DEBOUNCE_EN
    localparam int LAT = DEB;
`else
    localparam int LAT = 1;
`endif

    logic       pclk = 1'b0;
    logic       pll_lckd;
    logic [7:0] p1In, p2In;
    logic [5:0] joyIn;
    logic [1:0] coinIn;
    logic       testIn, serviceIn;

    int vectors     = 0;
    int miscompares = 0;

    jamma_input_scanner_if bus();

    // Models the external JAMMA mux that JSELECT steers.
    assign bus.JJOY     = bus.JSELECT ? p2In : p1In;
    assign bus.JOYSTICK = joyIn;
    assign bus.JCOIN    = coinIn;
    assign bus.JTEST    = testIn;
    assign bus.JSERVICE = serviceIn;

    jamma_input_scanner #(
        .SETTLE_CYC (SETTLE),
        .DEB_SCANS  (DEB)
    ) dut (
        .pclk     (pclk),
        .pll_lckd (pll_lckd),
        .bus      (bus)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at t=%0t: got %h, want %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] p1, input logic [7:0] p2, input logic [5:0] joy,
                                 input logic [1:0] coinV, input logic testV, input logic serviceV);
        p1In      = p1;
        p2In      = p2;
        joyIn     = joy;
        coinIn    = coinV;
        testIn    = testV;
        serviceIn = serviceV;
    endtask

    task automatic waitScanValid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge pclk);
            if (bus.scan_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scanValidTimeout at t=%0t: got no pulse, want one within %0d cycles", $time, 3 * PERIOD);
        end
    endtask

    // Releases reset just after an edge and returns on the negedge of the first scan_valid.
    task automatic releaseReset();
        int edges;
        edges = 0;
        @(posedge pclk);
        #1 pll_lckd = 1'b1;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            @(posedge pclk);
            edges++;
            @(negedge pclk);
            if (bus.scan_valid === 1'b1) break;
        end
        checkOutput("firstValidEdge", 8'(edges), 8'(PERIOD + 1));
    endtask

    // Reference model: scan schedule from cycle arithmetic, filtering from scan history.
    int          cyc = 0;
    logic [7:0]  mA = 8'hFF;
    logic [7:0]  mB = 8'hFF;
    logic [3:0]  mCab = 4'hF;
    logic [19:0] scanWord;
    logic [19:0] expOut = '1;
    logic        expValid = 1'b0;
    logic [19:0] hist[$];
`ifdef JAMMA_DEBOUNCE_EN
    bit          allDiff;
`endif

    always @(posedge pclk or negedge pll_lckd) begin
        if (!pll_lckd) begin
            cyc      = 0;
            mA       = 8'hFF;
            mB       = 8'hFF;
            mCab     = 4'hF;
            expOut   = '1;
            expValid = 1'b0;
            hist.delete();
        end else begin
            cyc++;
            expValid = 1'b0;
            if (cyc % PERIOD == SETTLE) mA = p1In & {2'b11, joyIn};
            if (cyc % PERIOD == 0) begin
                mB   = p2In;
                mCab = {coinIn, testIn, serviceIn};
            end
            if (cyc > PERIOD && cyc % PERIOD == 1) begin
                scanWord = {mCab, mB, mA};
                expValid = 1'b1;
`ifdef JAMMA_DEBOUNCE_EN
                hist.push_back(scanWord);
                if (hist.size() > 16) void'(hist.pop_front());
                for (int b = 0; b < 20; b++) begin
                    if (hist.size() >= DEB) begin
                        allDiff = 1'b1;
                        for (int k = 1; k <= DEB; k++) begin
                            if (hist[hist.size() - k][b] == expOut[b]) allDiff = 1'b0;
                        end
                        if (allDiff) expOut[b] = scanWord[b];
                    end
                end
`else
                expOut = scanWord;
`endif
            end
        end
    end

    always @(negedge pclk) begin
        checkOutput("JSELECT",   {7'd0, bus.JSELECT},    {7'd0, (cyc % PERIOD) >= SETTLE});
        checkOutput("scanValid", {7'd0, bus.scan_valid}, {7'd0, expValid});
        checkOutput("joystick1", bus.joystick1,          expOut[7:0]);
        checkOutput("joystick2", bus.joystick2,          expOut[15:8]);
        checkOutput("coin",      {6'd0, bus.coin},       {6'd0, expOut[19:18]});
        checkOutput("cabinet",   {6'd0, bus.test_n, bus.service_n}, {6'd0, expOut[17:16]});
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog at t=%0t: got no finish, want finish", $time);
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        pll_lckd = 1'b0;
        applyStimulus(8'hFF, 8'hFF, 6'h3F, 2'b11, 1'b1, 1'b1);
        repeat (3) @(posedge pclk);
        #2;
        checkOutput("resetJselect", {7'd0, bus.JSELECT},    8'h00);
        checkOutput("resetValid",   {7'd0, bus.scan_valid}, 8'h00);
        checkOutput("resetJoy1",    bus.joystick1,          8'hFF);
        checkOutput("resetJoy2",    bus.joystick2,          8'hFF);
        checkOutput("resetCoin",    {6'd0, bus.coin},       8'h03);
        checkOutput("resetCab",     {6'd0, bus.test_n, bus.service_n}, 8'h03);

        releaseReset();

        applyStimulus(8'hFE, 8'hFF, 6'h3F, 2'b11, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            waitScanValid();
            checkOutput("bankAJoy1", bus.joystick1, (k >= LAT) ? 8'hFE : 8'hFF);
            checkOutput("bankAJoy2", bus.joystick2, 8'hFF);
        end

        applyStimulus(8'hFF, 8'hFF, 6'h3F, 2'b11, 1'b1, 1'b1);
        repeat (3) waitScanValid();
        checkOutput("restoreJoy1", bus.joystick1, 8'hFF);

        // Local stick glitch shorter than the debounce window.
        applyStimulus(8'hFF, 8'hFF, 6'h3E, 2'b11, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            if (k == 3) applyStimulus(8'hFF, 8'hFF, 6'h3F, 2'b11, 1'b1, 1'b1);
            waitScanValid();
            checkOutput("glitchJoy1", bus.joystick1, (LAT == 1 && k <= 2) ? 8'hFE : 8'hFF);
        end

        applyStimulus(8'hFF, 8'hFF, 6'h3F, 2'b10, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            waitScanValid();
            checkOutput("coinPress", {6'd0, bus.coin}, (k >= LAT) ? 8'h02 : 8'h03);
        end
        applyStimulus(8'hFF, 8'hFF, 6'h3F, 2'b11, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            waitScanValid();
            checkOutput("coinRelease", {6'd0, bus.coin}, (k >= LAT) ? 8'h03 : 8'h02);
        end

        // Reset in SEL_B with two disagreeing scans pending on joystick2.
        applyStimulus(8'hFF, 8'h7F, 6'h3F, 2'b11, 1'b1, 1'b1);
        repeat (2) waitScanValid();
        checkOutput("pendingJoy2", bus.joystick2, (LAT <= 2) ? 8'h7F : 8'hFF);
        repeat (10) @(posedge pclk);
        #1 pll_lckd = 1'b0;
        #2;
        checkOutput("midResetJselect", {7'd0, bus.JSELECT},    8'h00);
        checkOutput("midResetValid",   {7'd0, bus.scan_valid}, 8'h00);
        checkOutput("midResetJoy2",    bus.joystick2,          8'hFF);
        checkOutput("midResetCoin",    {6'd0, bus.coin},       8'h03);
        @(posedge pclk);
        releaseReset();
        checkOutput("freshJoy2", bus.joystick2, (LAT <= 1) ? 8'h7F : 8'hFF);
        for (int k = 2; k <= 3; k++) begin
            waitScanValid();
            checkOutput("freshJoy2", bus.joystick2, (k >= LAT) ? 8'h7F : 8'hFF);
        end

        // Mixed directed patterns; bits 7:6 of bank A must ignore the local stick.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(i[0] ? 8'h25 : 8'hFF,
                          (i < 4) ? 8'h3C : 8'hFF,
                          (i >= 2 && i <= 6) ? 6'h2A : 6'h3F,
                          (i < 5) ? 2'b01 : 2'b11,
                          (i >= 3) ? 1'b0 : 1'b1,
                          (i >= 1 && i <= 4) ? 1'b0 : 1'b1);
            waitScanValid();
        end
        checkOutput("mixedTest", {7'd0, bus.test_n}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
